// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a byte stream (4-byte count header + LE words) into
// word-aligned memory writes and holds the processor in reset until the image is in.
module imem_loader #(
    parameter int DEPTH = 101,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    state_t           state_r;
    logic [1:0]       byte_idx_r;
    logic [CNT_W-1:0] word_idx_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      asm_r;

    logic             accept_s;
    logic             word_end_s;
    logic [31:0]      asm_next_s;
    logic [CNT_W-1:0] hdr_count_s;
    logic [31:0]      word_addr_s;

    // Little-endian byte placement: stream byte k of a word lands in bits [8k+7:8k].
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  pos,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (pos)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    // in_ready depends on state only, so there is no path from in_valid back to in_ready.
    assign in_ready    = (state_r == ST_HEADER) || (state_r == ST_DATA);
    assign accept_s    = in_valid & in_ready;
    assign word_end_s  = accept_s && (byte_idx_r == 2'd3);
    assign asm_next_s  = insert_byte(asm_r, byte_idx_r, in_data);
    assign hdr_count_s = CNT_W'(asm_next_s);
    assign word_addr_s = 32'(word_idx_r);

    // Load sequencer with registered memory-port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            byte_idx_r <= 2'd0;
            word_idx_r <= ZERO_C;
            count_r    <= ZERO_C;
            asm_r      <= 32'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept_s) begin
                asm_r      <= asm_next_s;
                byte_idx_r <= byte_idx_r + 2'd1;
            end
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_r    <= ST_HEADER;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                        byte_idx_r <= 2'd0;
                        word_idx_r <= ZERO_C;
                        asm_r      <= 32'd0;
                    end
                end
                ST_HEADER: begin
                    if (word_end_s) begin
                        count_r <= hdr_count_s;
                        if (hdr_count_s == ZERO_C) begin
                            state_r  <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (hdr_count_s > DEPTH_C) begin
                            state_r <= ST_ERROR;
                            error   <= 1'b1;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_end_s) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_addr_s << 2'd2;
                        mem_wdata  <= asm_next_s;
                        word_idx_r <= word_idx_r + ONE_C;
                        if (word_idx_r == count_r - ONE_C) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                // The final write strobe is high during this state.
                ST_FLUSH: begin
                    state_r  <= ST_DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cpu_hold <= 1'b0;
                    done     <= 1'b0;
                    error    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the processor's word-addressed instruction memory. It receives a program image as a byte stream (valid/ready), assembles little-endian 32-bit words, and drives a one-word-per-cycle write port into instruction memory at byte addresses 0, 4, 8, … (word aligned, matching the memory's `a[31:2]` indexing). While loading it holds the processor in reset; it releases the processor when the image is complete.

## Interface

Parameters:

- `DEPTH`, default 101: number of 32-bit words in instruction memory.
- `CNT_W`, default 32: width of the header word count and the internal word counters.

Ports:

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the loader accepts the byte. A byte transfers on a cycle where `in_valid & in_ready`.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  32  byte address, always a multiple of 4.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  processor reset request; high while a load is in progress.
- `done`  out  1  level; the last load completed successfully.
- `error`  out  1  level; the last load was rejected (oversize).

## Operation

- **Stream format:** a 4-byte header carrying word count N, little-endian (first byte = bits [7:0]), followed by N×4 data bytes. Each word is also little-endian.
- **States:**
  - IDLE, HEADER, DATA, FLUSH, DONE, ERROR.
- **Transitions:**
  - IDLE/DONE/ERROR + `start` → HEADER. Clears `done`, `error`, the byte index, the word index and the assembly register.
  - HEADER: `in_ready`=1. On the 4th accepted byte, latch N, then:
    - N==0 → DONE.
    - N>DEPTH → ERROR.
    - otherwise → DATA.
  - DATA: `in_ready`=1. Bytes shift into the assembly register at byte position `byte_idx`. When the 4th byte of a word is accepted:
    - register `mem_wdata` = completed word and `mem_addr` = `word_idx`<<2;
    - pulse `mem_we` on the next cycle;
    - increment `word_idx`.
  - DATA, 4th byte of word N−1 accepted → FLUSH. In FLUSH, `in_ready`=0 and the final `mem_we` pulse is issued.
  - FLUSH → DONE after one cycle.
  - DONE, ERROR: `in_ready`=0. Remain until `start`.
- **`start` in HEADER/DATA/FLUSH** is ignored; an in-progress load is never aborted.
- **Output levels per state:**
  - `cpu_hold`=1 in HEADER, DATA, FLUSH and ERROR; 0 in IDLE and DONE.
  - `done`=1 only in DONE; `error`=1 only in ERROR.
- **Byte index** is 2 bits and wraps 3→0 at each word boundary. The word index never exceeds N (bounded by DEPTH).
- **Stalls:** cycles with `in_valid`=0 leave all state unchanged. There is no timeout.
- **Reset (asynchronous, any time, including mid-load):**
  - state → IDLE;
  - outputs `in_ready`, `mem_we`, `cpu_hold`, `done`, `error` = 0;
  - `mem_addr` and `mem_wdata` = 0.
  - A partially written memory is not cleared.

## Timing

- Accept-to-write latency: 4th byte of a word accepted at edge t → `mem_we`=1 during cycle t..t+1 (registered), with `mem_addr` and `mem_wdata` stable in that cycle.
- Maximum throughput is one byte per cycle, so one write per 4 cycles. `mem_we` is never high on two consecutive cycles.
- Last byte accepted at edge t:
  - FLUSH (final `mem_we`) during t..t+1;
  - DONE from t+1 (`done`=1, `cpu_hold`=0 visible after edge t+1).
- `start` at edge t → HEADER, with `in_ready`=1 and `cpu_hold`=1 from edge t.
- Header 4th byte accepted at edge t → DATA, DONE or ERROR from edge t. The first data byte can be accepted on the next cycle.
- All outputs are registered, except `in_ready`, which is decoded from state only (no combinational path from `in_valid`).

## Test plan

- **Reset values:** `rst_n`=0 then release → all outputs 0, state IDLE. Bytes presented with `in_valid`=1 are not accepted.
- **Three-word load, no stalls:** `start`; header 03 00 00 00; words E3A01007, E3A02002, E1A03231 sent LSB-first. Required:
  - three `mem_we` pulses at addr 0x0, 0x4, 0x8 with those values, each one cycle after its 4th byte;
  - `done`=1 and `cpu_hold`=0 one cycle after the final write.
- **Stalls:** same image with `in_valid` randomly deasserted → identical write sequence. No writes or state change occur during stalls.
- **Boundary counts:**
  - N=0 → DONE right after the header, no `mem_we`.
  - N=101 → 101 writes, last at 0x190.
  - N=102 → ERROR with `error`=1 and `cpu_hold`=1, no `mem_we`, `in_ready`=0.
- **Reset mid-load:** assert `rst_n`=0 in DATA after 2 bytes of word 1 → outputs 0 immediately (asynchronous). A new `start` plus a full image then loads from addr 0 with correct words (no stale partial bytes).
- **Start ignored / restart:** `start` pulsed in DATA → no effect, load completes normally. `start` in DONE → `done` clears and a second image overwrites from addr 0.
